// File: rtl/memory.sv
// Hack-style unified data memory: data RAM, screen RAM and a keyboard word behind one 16-bit address.
// Optional keyboard input register enabled by MEMORY_KBD_EN; otherwise the KBD address reads 0.
module memory #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned RAM_DEPTH    = 16384,
    parameter int unsigned SCREEN_DEPTH = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inM,
    input  logic [15:0]       address,
    input  logic              load,
`ifdef MEMORY_KBD_EN
    input  logic [DATA_W-1:0] kbd,
`endif
    output logic [DATA_W-1:0] outM
);

    localparam int unsigned RAM_AW      = $clog2(RAM_DEPTH);
    localparam int unsigned SCR_AW      = $clog2(SCREEN_DEPTH);
    localparam int unsigned SCREEN_BASE = RAM_DEPTH;
    localparam int unsigned KBD_ADDR    = RAM_DEPTH + SCREEN_DEPTH;

    logic [DATA_W-1:0] ram_q [RAM_DEPTH];
    logic [DATA_W-1:0] scr_q [SCREEN_DEPTH];

    logic [31:0]       addr_ext_c;
    logic              hit_ram_c;
    logic              hit_scr_c;
    logic              hit_kbd_c;
    logic [RAM_AW-1:0] ram_idx_c;
    logic [SCR_AW-1:0] scr_idx_c;
    logic              ram_we_c;
    logic              scr_we_c;
    logic [DATA_W-1:0] kbd_rd_c;
    logic [DATA_W-1:0] rd_data_c;

    // Region decode; everything above the KBD word is unmapped.
    always_comb begin
        addr_ext_c = 32'(address);
        hit_ram_c  = 1'b0;
        hit_scr_c  = 1'b0;
        hit_kbd_c  = 1'b0;
        ram_idx_c  = RAM_AW'(addr_ext_c);
        scr_idx_c  = SCR_AW'(addr_ext_c - SCREEN_BASE);
        if (addr_ext_c < RAM_DEPTH) begin
            hit_ram_c = 1'b1;
        end else if (addr_ext_c < KBD_ADDR) begin
            hit_scr_c = 1'b1;
        end else if (addr_ext_c == KBD_ADDR) begin
            hit_kbd_c = 1'b1;
        end
    end

    // Writes are blocked while reset is low; KBD and unmapped writes fall through.
    always_comb begin
        ram_we_c = load && reset && hit_ram_c;
        scr_we_c = load && reset && hit_scr_c;
    end

    // Storage arrays are deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram_q[ram_idx_c] <= inM;
        end
        if (scr_we_c) begin
            scr_q[scr_idx_c] <= inM;
        end
    end

`ifdef MEMORY_KBD_EN
    logic [DATA_W-1:0] kbd_q;
    logic [DATA_W-1:0] kbd_d;

    always_comb begin
        kbd_d = kbd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_q <= '0;
        end else begin
            kbd_q <= kbd_d;
        end
    end

    assign kbd_rd_c = kbd_q;
`else
    assign kbd_rd_c = '0;
`endif

    // Combinational read mux, forced to zero during reset.
    always_comb begin
        rd_data_c = '0;
        if (hit_ram_c) begin
            rd_data_c = ram_q[ram_idx_c];
        end else if (hit_scr_c) begin
            rd_data_c = scr_q[scr_idx_c];
        end else if (hit_kbd_c) begin
            rd_data_c = kbd_rd_c;
        end
        outM = reset ? rd_data_c : '0;
    end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed scenarios plus randomized traffic against an address->word map model.
module tb_memory;

    logic        clk;
    logic        reset;
    logic [15:0] inM;
    logic [15:0] address;
    logic        load;
    logic [15:0] outM;
`ifdef MEMORY_KBD_EN
    logic [15:0] kbd;
`endif

    int total;
    int bad;

    // Reference model: only words that were actually written are known.
    logic [15:0] ref_mem [int];
    logic [15:0] kbd_exp;

    memory dut (
        .clk     (clk),
        .reset   (reset),
        .inM     (inM),
        .address (address),
        .load    (load),
`ifdef MEMORY_KBD_EN
        .kbd     (kbd),
`endif
        .outM    (outM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_rd(input logic [15:0] a);
        if (!reset) return 16'h0000;
        if (a < 16'd24576) return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'hxxxx;
        if (a == 16'd24576) return kbd_exp;
        return 16'h0000;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
        if (reset && a < 16'd24576) ref_mem[int'(a)] = d;
    endfunction

    // Drive one access across a rising edge and sample just after it.
    task automatic cycle(input logic [15:0] a, input logic [15:0] d, input logic ld);
        @(negedge clk);
        address = a;
        inM     = d;
        load    = ld;
        @(posedge clk);
        if (ld) model_write(a, d);
        #1;
        load = 1'b0;
    endtask

    task automatic set_addr(input logic [15:0] a);
        @(negedge clk);
        address = a;
        load    = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        logic [15:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom);
            address = a;
            #1;
            total++;
            if (outM !== 16'h0000) begin
                bad++;
                $display("FAIL reset_out addr=%h: got %h want 0000", a, outM);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        cycle(16'd5, 16'd7, 1'b1);
        set_addr(16'd5);
        total++;
        if (outM !== 16'd7) begin
            bad++;
            $display("FAIL first_write: got %h want %h", outM, 16'd7);
        end
    endtask

    task automatic test_ram_screen;
        cycle(16'd12345, 16'd12345, 1'b1);
        set_addr(16'd12345);
        total++;
        if (outM !== 16'd12345) begin
            bad++;
            $display("FAIL ram_rw: got %h want %h", outM, 16'd12345);
        end
        cycle(16'd23456, 16'd23456, 1'b1);
        set_addr(16'd23456);
        total++;
        if (outM !== 16'd23456) begin
            bad++;
            $display("FAIL screen_rw: got %h want %h", outM, 16'd23456);
        end
        set_addr(16'd12345);
        total++;
        if (outM !== 16'd12345) begin
            bad++;
            $display("FAIL no_alias: got %h want %h", outM, 16'd12345);
        end
    endtask

    task automatic test_load_gating;
        cycle(16'd1000, 16'h0BAD, 1'b1);
        cycle(16'd1000, 16'd1000, 1'b0);
        total++;
        if (outM !== 16'h0BAD) begin
            bad++;
            $display("FAIL load_low: got %h want %h", outM, 16'h0BAD);
        end
        cycle(16'd1000, 16'd1000, 1'b1);
        total++;
        if (outM !== 16'd1000) begin
            bad++;
            $display("FAIL load_high: got %h want %h", outM, 16'd1000);
        end
    endtask

    task automatic test_boundaries;
        cycle(16'd16383, 16'hAAAA, 1'b1);
        cycle(16'd16384, 16'h5555, 1'b1);
        set_addr(16'd16383);
        total++;
        if (outM !== 16'hAAAA) begin
            bad++;
            $display("FAIL ram_top: got %h want AAAA", outM);
        end
        set_addr(16'd16384);
        total++;
        if (outM !== 16'h5555) begin
            bad++;
            $display("FAIL screen_base: got %h want 5555", outM);
        end
        cycle(16'd24575, 16'h1357, 1'b1);
        total++;
        if (outM !== 16'h1357) begin
            bad++;
            $display("FAIL screen_top: got %h want 1357", outM);
        end
        cycle(16'd24577, 16'hFFFF, 1'b1);
        total++;
        if (outM !== 16'h0000) begin
            bad++;
            $display("FAIL unmapped: got %h want 0000", outM);
        end
        cycle(16'd24576, 16'hBEEF, 1'b1);
        total++;
        if (outM !== kbd_exp) begin
            bad++;
            $display("FAIL kbd_write_ignored: got %h want %h", outM, kbd_exp);
        end
        set_addr(16'd0);
        total++;
        if (outM !== exp_rd(16'd0) && ref_mem.exists(0)) begin
            bad++;
            $display("FAIL addr0: got %h want %h", outM, exp_rd(16'd0));
        end
    endtask

    task automatic test_read_during_write;
        cycle(16'd777, 16'h1111, 1'b1);
        @(negedge clk);
        address = 16'd777;
        inM     = 16'h2222;
        load    = 1'b1;
        #1;
        total++;
        if (outM !== 16'h1111) begin
            bad++;
            $display("FAIL rdw_before: got %h want 1111", outM);
        end
        @(posedge clk);
        model_write(16'd777, 16'h2222);
        #1;
        load = 1'b0;
        total++;
        if (outM !== 16'h2222) begin
            bad++;
            $display("FAIL rdw_after: got %h want 2222", outM);
        end
    endtask

    task automatic test_reset_mid;
        cycle(16'd100, 16'h0042, 1'b1);
        @(negedge clk);
        address = 16'd100;
        inM     = 16'h1234;
        load    = 1'b1;
        reset   = 1'b0;
        #1;
        total++;
        if (outM !== 16'h0000) begin
            bad++;
            $display("FAIL reset_mid_out: got %h want 0000", outM);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        load  = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if (outM !== 16'h0042) begin
            bad++;
            $display("FAIL reset_retain: got %h want 0042", outM);
        end
    endtask

    task automatic test_random;
        logic [15:0] pool [16];
        logic [15:0] a;
        logic [15:0] d;
        logic        ld;
        for (int i = 0; i < 6; i++) pool[i] = 16'($urandom_range(0, 16383));
        for (int i = 6; i < 12; i++) pool[i] = 16'($urandom_range(16384, 24575));
        pool[12] = 16'd24576;
        for (int i = 13; i < 16; i++) pool[i] = 16'($urandom_range(24577, 65535));
        for (int i = 0; i < 12; i++) cycle(pool[i], 16'($urandom), 1'b1);
        for (int n = 0; n < 200; n++) begin
            a  = pool[$urandom_range(0, 15)];
            d  = 16'($urandom);
            ld = 1'($urandom_range(0, 1));
            @(negedge clk);
            address = a;
            inM     = d;
            load    = ld;
            #1;
            total++;
            if (outM !== exp_rd(a)) begin
                bad++;
                $display("FAIL rand_pre n=%0d addr=%h: got %h want %h", n, a, outM, exp_rd(a));
            end
            @(posedge clk);
            if (ld) model_write(a, d);
            #1;
            total++;
            if (outM !== exp_rd(a)) begin
                bad++;
                $display("FAIL rand_post n=%0d addr=%h: got %h want %h", n, a, outM, exp_rd(a));
            end
        end
        load = 1'b0;
    endtask

`ifdef MEMORY_KBD_EN
    task automatic test_kbd;
        @(negedge clk);
        reset   = 1'b0;
        kbd     = 16'h0041;
        address = 16'd24576;
        @(posedge clk);
        #1;
        total++;
        if (outM !== 16'h0000) begin
            bad++;
            $display("FAIL kbd_in_reset: got %h want 0000", outM);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (outM !== 16'h0000) begin
            bad++;
            $display("FAIL kbd_before_edge: got %h want 0000", outM);
        end
        @(posedge clk);
        kbd_exp = 16'h0041;
        #1;
        total++;
        if (outM !== 16'h0041) begin
            bad++;
            $display("FAIL kbd_latency: got %h want 0041", outM);
        end
        cycle(16'd24576, 16'h9999, 1'b1);
        total++;
        if (outM !== 16'h0041) begin
            bad++;
            $display("FAIL kbd_cpu_write: got %h want 0041", outM);
        end
    endtask
`endif

    initial begin
        total   = 0;
        bad     = 0;
        kbd_exp = 16'h0000;
        reset   = 1'b0;
        load    = 1'b0;
        inM     = 16'h0000;
        address = 16'h0000;
`ifdef MEMORY_KBD_EN
        kbd     = 16'h0000;
`endif
        test_reset();
        test_ram_screen();
        test_load_gating();
        test_boundaries();
        test_read_during_write();
        test_reset_mid();
        test_random();
`ifdef MEMORY_KBD_EN
        test_kbd();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
